// File: rtl/universal_deserializer_if.sv
// Serial-in / parallel-out bus for universal_deserializer.
// slave = deserializer side, master = link driver plus parallel consumer.
interface universal_deserializer_if #(
    parameter int WIDTH = 4
);
    logic             sdin;
    logic             sdin_valid;
    logic             sdin_sof;
    logic             dir;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             busy;
    logic             overflow;
    logic             parity_err;

    modport slave (
        input  sdin, sdin_valid, sdin_sof, dir, dout_ready,
        output dout, dout_valid, busy, overflow, parity_err
    );

    modport master (
        output sdin, sdin_valid, sdin_sof, dir, dout_ready,
        input  dout, dout_valid, busy, overflow, parity_err
    );
endinterface

// File: rtl/universal_deserializer.sv
// Rebuilds WIDTH-bit words from an MSB- or LSB-first serial stream into a one-word
// valid/ready holding register. Define UNIV_DESER_PARITY_EN to append a parity bit per word.
module universal_deserializer #(
    parameter int   WIDTH      = 4,
    parameter logic PARITY_ODD = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    universal_deserializer_if.slave bus
);

`ifdef UNIV_DESER_PARITY_EN
    localparam logic PARITY_EN = 1'b1;
    localparam int   NBITS     = WIDTH + 1;
`else
    localparam logic PARITY_EN = 1'b0;
    localparam int   NBITS     = WIDTH;
`endif
    localparam int            CW   = $clog2(NBITS);
    localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] sr;
    logic             dir_q;
    logic             par_acc;
    logic [WIDTH-1:0] dout_q;
    logic             dout_valid_q;
    logic             overflow_q;
    logic             busy_q;
    logic             perr_q;

    logic [CW-1:0]    cnt_base;
    logic [CW-1:0]    cnt_next;
    logic             first;
    logic             dir_eff;
    logic [WIDTH-1:0] sr_shift;
    logic [WIDTH-1:0] sr_next;
    logic [WIDTH-1:0] word;
    logic             par_next;
    logic             perr_next;
    logic             complete;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        cnt_base  = bus.sdin_sof ? '0 : bit_cnt;
        first     = (cnt_base == '0);
        dir_eff   = first ? bus.dir : dir_q;
        sr_shift  = dir_eff ? {bus.sdin, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], bus.sdin};
        // The trailing parity bit is accumulated but never shifted into the data.
        sr_next   = (PARITY_EN && (cnt_base == LAST)) ? sr : sr_shift;
        word      = PARITY_EN ? sr : sr_shift;
        par_next  = (first ? 1'b0 : par_acc) ^ bus.sdin;
        perr_next = PARITY_EN && (par_next != PARITY_ODD);
        complete  = bus.sdin_valid && (cnt_base == LAST);
        cnt_next  = complete ? '0 : cnt_base + CW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt      <= '0;
            sr           <= '0;
            dir_q        <= 1'b0;
            par_acc      <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
            perr_q       <= 1'b0;
        end else begin
            if (bus.sdin_valid) begin
                bit_cnt <= cnt_next;
                sr      <= sr_next;
                dir_q   <= dir_eff;
                par_acc <= par_next;
                busy_q  <= (cnt_next != '0);
            end
            // A completing word replaces the held one only if the slot is free or drains now.
            if (complete) begin
                if (!dout_valid_q || bus.dout_ready) begin
                    dout_q       <= word;
                    perr_q       <= perr_next;
                    dout_valid_q <= 1'b1;
                end else begin
                    overflow_q   <= 1'b1;
                end
            end else if (dout_valid_q && bus.dout_ready) begin
                dout_valid_q <= 1'b0;
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.busy       = busy_q;
    assign bus.overflow   = overflow_q;
    assign bus.parity_err = perr_q & dout_valid_q;

endmodule

// File: tb/tb_universal_deserializer.sv
// Directed scoreboard bench for universal_deserializer (WIDTH=4); parity steps run
// only when UNIV_DESER_PARITY_EN is defined.
module tb_universal_deserializer;
    localparam int   W     = 4;
    localparam logic P_ODD = 1'b0;
`ifdef UNIV_DESER_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    typedef struct {
        logic [W-1:0] w;
        logic         perr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    universal_deserializer_if #(.WIDTH(W)) bus ();

    universal_deserializer #(.WIDTH(W), .PARITY_ODD(P_ODD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    logic m_valid;
    logic m_ovf;
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic sof, input logic d);
        bus.sdin       = b;
        bus.sdin_valid = 1'b1;
        bus.sdin_sof   = sof;
        bus.dir        = d;
        @(negedge clk);
        bus.sdin_valid = 1'b0;
        bus.sdin_sof   = 1'b0;
        bus.sdin       = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.sdin_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
            e = q.pop_front();
            check({tag, "_valid"}, 32'(bus.dout_valid), 32'd1);
            check({tag, "_dout"}, 32'(bus.dout), 32'(e.w));
            check({tag, "_perr"}, 32'(bus.parity_err), 32'(e.perr));
        end
    endtask

    task automatic consume(input string tag);
        pop_check(tag);
        bus.dout_ready = 1'b1;
        @(negedge clk);
        bus.dout_ready = 1'b0;
        m_valid = 1'b0;
        check({tag, "_cleared"}, 32'(bus.dout_valid), 32'd0);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.sdin_valid = 1'b0;
        bus.sdin_sof   = 1'b0;
        bus.dout_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q.delete();
        m_valid = 1'b0;
        m_ovf   = 1'b0;
    endtask

    // Sends one word; the model decides whether it lands in the holding register or is dropped.
    task automatic send_word(input string tag, input logic [W-1:0] w, input logic d, input int gap,
                             input logic tog, input logic sof, input logic rdy_last,
                             input logic bad_par);
        logic b;
        for (int i = 0; i < NB; i++) begin
            if (i < W) b = d ? w[i] : w[W-1-i];
            else       b = (^w) ^ P_ODD ^ bad_par;
            if (i == NB - 1) begin
                if (!m_valid) check({tag, "_not_early"}, 32'(bus.dout_valid), 32'd0);
                if (rdy_last && m_valid) begin
                    pop_check({tag, "_replaced"});
                    bus.dout_ready = 1'b1;
                end
            end
            send_bit(b, sof && (i == 0), (tog && i > 0) ? ~d : d);
            bus.dout_ready = 1'b0;
            if (i < NB - 1) begin
                idle(gap);
                check({tag, "_busy"}, 32'(bus.busy), 32'd1);
            end
        end
        if (!m_valid || rdy_last) begin
            q.push_back('{w: w, perr: bad_par});
            m_valid = 1'b1;
        end else begin
            m_ovf = 1'b1;
        end
        check({tag, "_valid_after"}, 32'(bus.dout_valid), 32'd1);
        check({tag, "_overflow"}, 32'(bus.overflow), 32'(m_ovf));
        check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.sdin       = 1'b0;
        bus.sdin_valid = 1'b0;
        bus.sdin_sof   = 1'b0;
        bus.dir        = 1'b0;
        bus.dout_ready = 1'b0;
        @(negedge clk);
        do_reset();
        check("rst_dout", 32'(bus.dout), 32'd0);
        check("rst_valid", 32'(bus.dout_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_perr", 32'(bus.parity_err), 32'd0);

        // Reset in the middle of a word, then a fresh word must assemble cleanly.
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        check("mid_busy", 32'(bus.busy), 32'd1);
        do_reset();
        check("midrst_dout", 32'(bus.dout), 32'd0);
        check("midrst_valid", 32'(bus.dout_valid), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_overflow", 32'(bus.overflow), 32'd0);
        send_word("fresh", 4'b0101, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        consume("fresh");

        // MSB-first with idle gaps, held while the consumer stalls.
        send_word("msb_gap", 4'b1010, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.dout_valid), 32'd1);
            check("hold_dout", 32'(bus.dout), 32'b1010);
        end
        consume("msb_gap");

        // LSB-first with dir toggling after the first bit.
        send_word("lsb_tog", 4'b0111, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        consume("lsb_tog");

        // Second word dropped while the first is still held.
        send_word("ovf_a", 4'b0011, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word("ovf_b", 4'b1100, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        consume("ovf_kept");
        check("ovf_sticky", 32'(bus.overflow), 32'd1);
        do_reset();
        check("ovf_cleared", 32'(bus.overflow), 32'd0);

        // Completion coinciding with the consumer draining the old word.
        send_word("rep_a", 4'b0011, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word("rep_b", 4'b1100, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        consume("rep_b");

        // Start-of-frame discards a partial word.
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_word("sof", 4'b0110, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        consume("sof");
        check("sof_no_ovf", 32'(bus.overflow), 32'd0);

`ifdef UNIV_DESER_PARITY_EN
        send_word("par_good", 4'b1010, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        consume("par_good");
        send_word("par_bad", 4'b1010, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        consume("par_bad");
`endif

        check("sb_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
